// File: rtl/ysyx_22051468_mul_div_unit_pkg.sv
// Shared definitions for the RV64M multiply/divide unit.
//   XLEN, iteration-counter width, funct3 codes, FSM state encoding and
//   small helpers for operand extension and result formatting.
package ysyx_22051468_mul_div_unit_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = 6;

    localparam logic [2:0] MDU_F3_MUL    = 3'b000;
    localparam logic [2:0] MDU_F3_MULH   = 3'b001;
    localparam logic [2:0] MDU_F3_MULHSU = 3'b010;
    localparam logic [2:0] MDU_F3_MULHU  = 3'b011;
    localparam logic [2:0] MDU_F3_DIV    = 3'b100;
    localparam logic [2:0] MDU_F3_DIVU   = 3'b101;
    localparam logic [2:0] MDU_F3_REM    = 3'b110;
    localparam logic [2:0] MDU_F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] w_fix(input logic [XLEN-1:0] v, input logic is_w);
        return is_w ? sext32(v[31:0]) : v;
    endfunction

    function automatic logic [XLEN-1:0] ext_op(input logic [XLEN-1:0] v, input logic is_w,
                                               input logic sgn);
        if (!is_w) return v;
        return sgn ? sext32(v[31:0]) : {{(XLEN-32){1'b0}}, v[31:0]};
    endfunction

    // Index of the final iteration: 32 steps for W ops, 64 otherwise.
    function automatic logic [CNT_W-1:0] last_cnt(input logic is_w);
        return is_w ? CNT_W'(31) : CNT_W'(63);
    endfunction

    // {rs1 signed, rs2 signed}
    function automatic logic [1:0] op_signs(input logic [2:0] f3);
        case (f3)
            MDU_F3_MUL, MDU_F3_MULH, MDU_F3_DIV, MDU_F3_REM: return 2'b11;
            MDU_F3_MULHSU:                                   return 2'b10;
            default:                                         return 2'b00;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] p, input logic is_w,
                                                 input logic hi);
        if (is_w) return sext32(p[31:0]);
        return hi ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
    endfunction

endpackage

// File: rtl/ysyx_22051468_mul_div_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
//   master: decoder/pipeline side (drives request, out_ready, flush)
//   slave : the unit (drives in_ready, out_valid, result_o)
interface ysyx_22051468_mul_div_unit_if;
    import ysyx_22051468_mul_div_unit_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic            is_mul;
    logic            is_div;
    logic            is_rem;
    logic            is_W;
    logic [2:0]      funct3;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result_o;

    modport master (
        output in_valid, is_mul, is_div, is_rem, is_W, funct3, src1, src2, flush, out_ready,
        input  in_ready, out_valid, result_o
    );

    modport slave (
        input  in_valid, is_mul, is_div, is_rem, is_W, funct3, src1, src2, flush, out_ready,
        output in_ready, out_valid, result_o
    );

endinterface

// File: rtl/ysyx_22051468_mul_div_unit_div_iter.sv
// ysyx_22051468_div_iter: restoring radix-2 divider on unsigned magnitudes,
// one quotient bit per cycle.
//   clk, rst    : clock, synchronous active-high reset
//   start_i     : load operands and begin (ignored while kill_i)
//   kill_i      : abandon the current division
//   is_w_i      : 32 iterations instead of 64 (sampled at start)
//   dividend_i  : dividend magnitude
//   divisor_i   : divisor magnitude (non-zero)
//   done_o      : high during the final iteration cycle
//   quot_o/rem_o: quotient/remainder after this cycle's step; final when done_o
module ysyx_22051468_div_iter
    import ysyx_22051468_mul_div_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic            is_w_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quot_o,
    output logic [XLEN-1:0] rem_o
);

    logic             busy_q, busy_d;
    logic             is_w_q, is_w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  quot_q, quot_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  dsr_q, dsr_d;

    logic [XLEN:0]    rem_sh, diff;
    logic             ge;
    logic [XLEN-1:0]  quot_nxt, rem_nxt;

    // The partial remainder is always below the divisor, so the shifted
    // value fits in XLEN+1 bits and the top bit of the difference is the borrow.
    always_comb begin
        rem_sh   = {rem_q, quot_q[XLEN-1]};
        diff     = rem_sh - {1'b0, dsr_q};
        ge       = ~diff[XLEN];
        rem_nxt  = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quot_nxt = {quot_q[XLEN-2:0], ge};
    end

    assign done_o = busy_q && (cnt_q == last_cnt(is_w_q));
    assign quot_o = quot_nxt;
    assign rem_o  = rem_nxt;

    always_comb begin
        busy_d = busy_q;
        is_w_d = is_w_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dsr_d  = dsr_q;
        if (kill_i) begin
            busy_d = 1'b0;
        end else if (start_i) begin
            busy_d = 1'b1;
            is_w_d = is_w_i;
            cnt_d  = '0;
            // W dividends are pre-aligned to the top so 32 shifts bring
            // the quotient into the low half.
            quot_d = is_w_i ? {dividend_i[31:0], 32'b0} : dividend_i;
            rem_d  = '0;
            dsr_d  = divisor_i;
        end else if (busy_q) begin
            cnt_d  = cnt_q + 1'b1;
            quot_d = quot_nxt;
            rem_d  = rem_nxt;
            if (done_o) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            is_w_q <= 1'b0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
        end else begin
            busy_q <= busy_d;
            is_w_q <= is_w_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
        end
    end

endmodule

// File: rtl/ysyx_22051468_mul_div_unit.sv
// ysyx_22051468_mul_div_unit: multi-cycle RV64M execute unit (mul/div/rem and W forms).
//   clk, rst : clock, synchronous active-high reset
//   mdu      : slave side of ysyx_22051468_mul_div_unit_if (request, flush,
//              result handshake)
// Build option: MDU_FAST_MUL_EN selects a single-cycle multiplier; without it
// the multiplier is shift-add, one partial product per cycle.
//
// state    | meaning
// MDU_IDLE | ready for a request (in_ready=1)
// MDU_CALC | iterating: shift-add multiply or divider core running
// MDU_DONE | result_o valid, waiting for out_ready
module ysyx_22051468_mul_div_unit
    import ysyx_22051468_mul_div_unit_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    ysyx_22051468_mul_div_unit_if.slave mdu
);

    mdu_state_e       state_q, state_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             is_w_q, is_w_d;
    logic             is_rem_q, is_rem_d;
    logic             div_cls_q, div_cls_d;
    logic             sel_hi_q, sel_hi_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
`ifndef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] acc_nxt, prod;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`else
    logic [2*XLEN-1:0] fast_prod;
`endif

    logic            one_hot, accept;
    logic            sgn_a, sgn_b, neg_a, neg_b;
    logic            div_by_zero, div_ovf, special;
    logic [XLEN-1:0] op_a, op_b, mag_a, mag_b, most_neg, special_res;
    logic            div_start, div_done;
    logic [XLEN-1:0] div_q, div_r, div_res;

    assign mdu.in_ready  = (state_q == MDU_IDLE);
    assign mdu.out_valid = (state_q == MDU_DONE);
    assign mdu.result_o  = result_q;

    always_comb begin
        one_hot = {mdu.is_mul, mdu.is_div, mdu.is_rem} inside {3'b100, 3'b010, 3'b001};
        accept  = mdu.in_valid && (state_q == MDU_IDLE) && one_hot && !mdu.flush;
        {sgn_a, sgn_b} = op_signs(mdu.funct3);
        op_a  = ext_op(mdu.src1, mdu.is_W, sgn_a);
        op_b  = ext_op(mdu.src2, mdu.is_W, sgn_b);
        neg_a = sgn_a & op_a[XLEN-1];
        neg_b = sgn_b & op_b[XLEN-1];
        mag_a = neg_a ? -op_a : op_a;
        mag_b = neg_b ? -op_b : op_b;
        most_neg    = mdu.is_W ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        div_by_zero = (op_b == '0);
        div_ovf     = sgn_a && sgn_b && (op_a == most_neg) && (op_b == '1);
        special     = !mdu.is_mul && (div_by_zero || div_ovf);
        if (mdu.is_rem) special_res = div_by_zero ? op_a : '0;
        else            special_res = div_by_zero ? '1 : op_a;
    end

    // Remainder follows the dividend's sign; quotient is negated when signs differ.
    always_comb begin
        if (is_rem_q) div_res = neg_a_q ? -div_r : div_r;
        else          div_res = (neg_a_q ^ neg_b_q) ? -div_q : div_q;
        div_res = w_fix(div_res, is_w_q);
    end

`ifndef MDU_FAST_MUL_EN
    always_comb begin
        acc_nxt = mplier_q[0] ? acc_q + mcand_q : acc_q;
        prod    = (neg_a_q ^ neg_b_q) ? -acc_nxt : acc_nxt;
    end
`else
    assign fast_prod = {{XLEN{neg_a}}, op_a} * {{XLEN{neg_b}}, op_b};
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        is_w_d    = is_w_q;
        is_rem_d  = is_rem_q;
        div_cls_d = div_cls_q;
        sel_hi_d  = sel_hi_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        div_start = 1'b0;
`ifndef MDU_FAST_MUL_EN
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            MDU_IDLE: begin
                if (accept) begin
                    is_w_d    = mdu.is_W;
                    is_rem_d  = mdu.is_rem;
                    div_cls_d = !mdu.is_mul;
                    sel_hi_d  = (mdu.funct3[1:0] != 2'b00);
                    neg_a_d   = neg_a;
                    neg_b_d   = neg_b;
                    if (mdu.is_mul) begin
`ifdef MDU_FAST_MUL_EN
                        result_d = mul_pick(fast_prod, mdu.is_W, mdu.funct3[1:0] != 2'b00);
                        state_d  = MDU_DONE;
`else
                        mcand_d  = {{XLEN{1'b0}}, mag_a};
                        mplier_d = mag_b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = MDU_CALC;
`endif
                    end else if (special) begin
                        result_d = w_fix(special_res, mdu.is_W);
                        state_d  = MDU_DONE;
                    end else begin
                        div_start = 1'b1;
                        state_d   = MDU_CALC;
                    end
                end
            end
            MDU_CALC: begin
                if (div_cls_q) begin
                    if (div_done) begin
                        result_d = div_res;
                        state_d  = MDU_DONE;
                    end
                end
`ifndef MDU_FAST_MUL_EN
                else begin
                    acc_d    = acc_nxt;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == last_cnt(is_w_q)) begin
                        result_d = mul_pick(prod, is_w_q, sel_hi_q);
                        state_d  = MDU_DONE;
                    end
                end
`endif
            end
            MDU_DONE: begin
                if (mdu.out_ready) state_d = MDU_IDLE;
            end
            default: state_d = MDU_IDLE;
        endcase
        if (mdu.flush) begin
            state_d   = MDU_IDLE;
            result_d  = '0;
            div_start = 1'b0;
        end
    end

    ysyx_22051468_div_iter u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .kill_i     (mdu.flush),
        .is_w_i     (mdu.is_W),
        .dividend_i (mag_a),
        .divisor_i  (mag_b),
        .done_o     (div_done),
        .quot_o     (div_q),
        .rem_o      (div_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MDU_IDLE;
            result_q  <= '0;
            is_w_q    <= 1'b0;
            is_rem_q  <= 1'b0;
            div_cls_q <= 1'b0;
            sel_hi_q  <= 1'b0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
`ifndef MDU_FAST_MUL_EN
            mcand_q   <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            is_w_q    <= is_w_d;
            is_rem_q  <= is_rem_d;
            div_cls_q <= div_cls_d;
            sel_hi_q  <= sel_hi_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
`ifndef MDU_FAST_MUL_EN
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_ysyx_22051468_mul_div_unit.sv
module tb_ysyx_22051468_mul_div_unit;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT64 = 1;
    localparam int MUL_LAT32 = 1;
`else
    localparam int MUL_LAT64 = 65;
    localparam int MUL_LAT32 = 33;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ysyx_22051468_mul_div_unit_if mdu_if ();

    ysyx_22051468_mul_div_unit dut (
        .clk (clk),
        .rst (rst),
        .mdu (mdu_if)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic m, input logic d, input logic r, input logic w,
                           input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
        mdu_if.is_mul = m;
        mdu_if.is_div = d;
        mdu_if.is_rem = r;
        mdu_if.is_W   = w;
        mdu_if.funct3 = f3;
        mdu_if.src1   = a;
        mdu_if.src2   = b;
    endtask

    // Called #1 after a clock edge with the unit idle; returns #1 after the accept edge.
    task automatic issue(input logic m, input logic d, input logic r, input logic w,
                         input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
        set_req(m, d, r, w, f3, a, b);
        mdu_if.in_valid = 1'b1;
        @(posedge clk); #1;
        mdu_if.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!mdu_if.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic m, input logic d, input logic r,
                          input logic w, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
        int lat;
        issue(m, d, r, w, f3, a, b);
        wait_valid(lat);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, mdu_if.result_o, exp);
        mdu_if.out_ready = 1'b1;
        @(posedge clk); #1;
        mdu_if.out_ready = 1'b0;
        check({tag, " back to idle"}, {63'b0, mdu_if.in_ready}, 64'd1);
    endtask

    initial begin
        int  lat;
        logic seen;
        mdu_if.in_valid  = 1'b0;
        mdu_if.out_ready = 1'b0;
        mdu_if.flush     = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("reset in_ready", {63'b0, mdu_if.in_ready}, 64'd1);
        check("reset out_valid", {63'b0, mdu_if.out_valid}, 64'd0);
        check("reset result", mdu_if.result_o, 64'd0);

        run_op("mul 7*-3", 1,0,0,0, 3'b000, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT64);
        run_op("mulhu", 1,0,0,0, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h1, MUL_LAT64);
        run_op("mulh -1*-1", 1,0,0,0, 3'b001, '1, '1, 64'h0, MUL_LAT64);
        run_op("mulhsu -1*2", 1,0,0,0, 3'b010, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, MUL_LAT64);
        run_op("mulw", 1,0,0,1, 3'b000, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT32);
        run_op("div ovf", 0,1,0,0, 3'b100, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        run_op("rem ovf", 0,0,1,0, 3'b110, 64'h8000_0000_0000_0000, '1, 64'h0, 1);
        run_op("divuw 5/0", 0,1,0,1, 3'b101, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("remu 5/0", 0,0,1,0, 3'b111, 64'd5, 64'd0, 64'd5, 1);
        run_op("divw ovf", 0,1,0,1, 3'b100, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1);
        run_op("remw -7/2", 0,0,1,1, 3'b110, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("divw -7/2", 0,1,0,1, 3'b100, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        run_op("divuw max/1", 0,1,0,1, 3'b101, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("div 100/7", 0,1,0,0, 3'b100, 64'd100, 64'd7, 64'd14, 65);
        run_op("rem -100/7", 0,0,1,0, 3'b110, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run_op("divu max/3", 0,1,0,0, 3'b101, '1, 64'd3, 64'h5555_5555_5555_5555, 65);

        // malformed class flags are dropped
        issue(1, 1, 0, 0, 3'b000, 64'd3, 64'd3);
        issue(0, 0, 0, 0, 3'b000, 64'd3, 64'd3);
        repeat (3) @(posedge clk);
        #1;
        check("bad class out_valid", {63'b0, mdu_if.out_valid}, 64'd0);
        check("bad class in_ready", {63'b0, mdu_if.in_ready}, 64'd1);

        // flush wins over a simultaneous request
        mdu_if.flush = 1'b1;
        issue(0, 1, 0, 0, 3'b100, 64'd9, 64'd0);
        mdu_if.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("flush+req out_valid", {63'b0, mdu_if.out_valid}, 64'd0);
        check("flush+req in_ready", {63'b0, mdu_if.in_ready}, 64'd1);

        // backpressure: result held, new requests ignored
        issue(0, 1, 0, 0, 3'b100, 64'd100, 64'd7);
        wait_valid(lat);
        check("bp latency", 64'(lat), 64'd65);
        for (int i = 0; i < 10; i++) begin
            set_req(1, 0, 0, 0, 3'b000, 64'd5, 64'd5);
            mdu_if.in_valid = 1'b1;
            check("bp out_valid", {63'b0, mdu_if.out_valid}, 64'd1);
            check("bp result", mdu_if.result_o, 64'd14);
            check("bp in_ready", {63'b0, mdu_if.in_ready}, 64'd0);
            @(posedge clk); #1;
        end
        mdu_if.in_valid  = 1'b0;
        mdu_if.out_ready = 1'b1;
        @(posedge clk); #1;
        mdu_if.out_ready = 1'b0;
        check("bp handoff in_ready", {63'b0, mdu_if.in_ready}, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("bp no stray op", {63'b0, mdu_if.out_valid}, 64'd0);

        // flush at CALC cycle 20
        issue(0, 1, 0, 0, 3'b100, 64'd100, 64'd7);
        repeat (19) @(posedge clk);
        #1 mdu_if.flush = 1'b1;
        @(posedge clk); #1;
        mdu_if.flush = 1'b0;
        check("flush in_ready", {63'b0, mdu_if.in_ready}, 64'd1);
        check("flush out_valid", {63'b0, mdu_if.out_valid}, 64'd0);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (mdu_if.out_valid) seen = 1'b1;
        end
        check("flush no result", {63'b0, seen}, 64'd0);
        run_op("after flush divw", 0,1,0,1, 3'b100, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);

        // reset at CALC cycle 5
        issue(0, 1, 0, 0, 3'b100, 64'd100, 64'd7);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid rst out_valid", {63'b0, mdu_if.out_valid}, 64'd0);
        check("mid rst in_ready", {63'b0, mdu_if.in_ready}, 64'd1);
        check("mid rst result", mdu_if.result_o, 64'd0);
        run_op("after rst mul", 1,0,0,0, 3'b000, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
